run_ctrl_tick: RTL and testbench
================================

# run_ctrl_tick

Control stage that drives the enable input of the 4-bit up counter. It debounces two raw push-button inputs: a start/stop toggle and a clear. A two-state run/stop FSM gates a clock prescaler, so the counter advances one step per `DIV` clock cycles while running. It also emits a one-cycle `clear` pulse that the top level routes to the counter's clear/reset path.

## Interface
- `DIV`, default 4: prescaler ratio, meaning one `enable` pulse per `DIV` running cycles. Legal: `DIV` ≥ 1.
- `DB_CYCLES`, default 8: consecutive stable cycles required to accept a button level change. Legal: ≥ 1.
- `clock`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `btn_raw`  input  1  raw start/stop button, asynchronous, may bounce.
- `clr_raw`  input  1  raw clear button, asynchronous, may bounce.
- `enable`  output  1  one-cycle tick to the counter's `enable`.
- `running`  output  1  high while the FSM is in RUNNING.
- `clear`  output  1  one-cycle pulse per accepted clear press.

## Operation
- Each raw input passes through a 2-flop synchronizer, then a debouncer:
  - The debouncer holds a `stable` level and a run-length counter.
  - The counter clears whenever the synced level equals `stable`. Otherwise it increments.
  - On reaching `DB_CYCLES`, `stable` takes the synced level and the counter clears.
  - A press pulse fires for one cycle, in the cycle `stable` goes 0→1. Releases produce no pulse.
- FSM states: STOPPED (reset state) and RUNNING.
  - A btn press pulse toggles the state: STOPPED→RUNNING or RUNNING→STOPPED.
  - No other transitions.
- Prescaler `presc` runs from 0 to `DIV`-1, width max(1, $clog2(`DIV`)).
  - In RUNNING it increments each cycle and wraps from `DIV`-1 to 0.
  - In STOPPED it holds its value, so pause/resume preserves phase.
- `enable` = RUNNING && (`presc` == `DIV`-1). This output is combinational from registered state.
  - With `DIV` = 1, `enable` is high every RUNNING cycle.
- Clear press pulse:
  - `clear` is high in the same cycle as the pulse.
  - `presc` loads 0 at the next edge.
  - The FSM state is unchanged.
- Simultaneous btn and clr pulses both take effect: the state toggles and `presc` loads 0.
  - Clear has priority over increment.
- Reset (`reset` low, any time):
  - STOPPED, `presc` = 0, synchronizers = 0, `stable` = 0, debounce counters = 0.
  - `enable`, `running`, `clear` = 0 immediately, without waiting for a clock edge.
  - An in-progress debounce is discarded.

## Timing
- Raw input rises and stays high: the press pulse occurs in the cycle after the (`DB_CYCLES`+2)th rising edge that samples it high.
- Bounce shorter than `DB_CYCLES` cycles produces no pulse.
- `running` is registered and rises in the cycle after the btn pulse.
- From STOPPED with `presc` = p: the first `enable` comes (`DIV`-1-p) cycles after `running` rises.
  - When p = `DIV`-1, `enable` is high in the same cycle `running` rises.
- After a clear pulse in cycle c while running: the next `enable` is in cycle c+`DIV`.
- When RUNNING→STOPPED, `enable` is low from the cycle `running` falls.

## Structure
- Shared package `run_ctrl_pkg`:
  - State encoding constants `ST_STOPPED` = 1'b0 and `ST_RUNNING` = 1'b1.
  - Default `DIV` and `DB_CYCLES` values.
- Sub-module `debounce_pulse`, instantiated twice: synchronizer, debouncer and rising-edge pulse.
  - Parameter `DB_CYCLES`.
  - Ports `clock`, `reset`, `raw`, `level`, `press`.
- Top level holds the FSM, the prescaler and the output logic.

## Test plan
All scenarios use `DIV` = 4, `DB_CYCLES` = 8 and a 20 ns clock.
- Reset: hold `reset` low 3 cycles with buttons toggling → `enable`, `running`, `clear` stay 0. After release all remain 0 until a valid press.
- Bounce: `btn_raw` toggles every 2 cycles for 6 cycles, then stays high 20 cycles → exactly one press. `running` rises 11 cycles after the final rise. No second toggle.
- Run: running for 64 cycles driving the counter → exactly 16 `enable` pulses, spaced 4 cycles apart. Counter goes 0…15 and wraps to 0.
- Pause/resume: stop when `presc` = 2, wait 10 cycles, restart → no `enable` while stopped. The first `enable` comes 1 cycle after `running` rises.
- Clear: clear press while running → `clear` high exactly 1 cycle in cycle c, `running` stays 1, next `enable` in cycle c+4. Pressing btn and clr together → `running` toggles and `presc` restarts from 0.
- Mid-run reset: assert `reset` between clock edges while `enable` is high → all outputs drop to 0 at once. After release the block is STOPPED with `presc` = 0.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run/stop tick controller.
// Holds the FSM state encoding and default DIV / DB_CYCLES values.
package run_ctrl_pkg;

    localparam logic ST_STOPPED = 1'b0;
    localparam logic ST_RUNNING = 1'b1;

    localparam int DIV_DEFAULT       = 4;
    localparam int DB_CYCLES_DEFAULT = 8;

    typedef enum logic {
        STOPPED = ST_STOPPED,
        RUNNING = ST_RUNNING
    } state_t;

    // Prescaler width: never narrower than one bit, even for DIV = 1.
    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/debounce_pulse.sv
// Synchronizer + debouncer + rising-edge press pulse for one raw button.
// Ports: clock, reset (async active-low), raw in; level (debounced), press (1-cycle).
module debounce_pulse
    import run_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    logic w_diff;
    logic w_hit;

    assign w_diff = (r_sync2 != r_stable);
    // DB_CYCLES-th consecutive differing sample: accept the new level.
    assign w_hit  = w_diff && (r_cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_hit) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            // Pulse only when the accepted level goes 0 -> 1.
            r_press <= w_hit && r_sync2;
        end
    end

    assign level = r_stable;
    assign press = r_press;

endmodule

// File: rtl/run_ctrl_tick.sv
// Run/stop control stage producing the counter enable tick and clear pulse.
// Ports: clock, reset (async active-low), btn_raw, clr_raw in; enable, running, clear out.
module run_ctrl_tick
    import run_ctrl_pkg::*;
#(
    parameter int DIV       = DIV_DEFAULT,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    input  logic clr_raw,
    output logic enable,
    output logic running,
    output logic clear
);

    localparam int PW = presc_width(DIV);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic w_btn_level;
    logic w_btn_press;
    logic w_clr_level;
    logic w_clr_press;
    logic w_unused;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;

    debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_btn (
        .clock (clock),
        .reset (reset),
        .raw   (btn_raw),
        .level (w_btn_level),
        .press (w_btn_press)
    );

    debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_clr (
        .clock (clock),
        .reset (reset),
        .raw   (clr_raw),
        .level (w_clr_level),
        .press (w_clr_press)
    );

    // Debounced levels are not needed here; only the press pulses are.
    assign w_unused = &{1'b0, w_btn_level, w_clr_level};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= STOPPED;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        if (w_btn_press) begin
            unique case (r_state)
                STOPPED: w_state_nxt = RUNNING;
                RUNNING: w_state_nxt = STOPPED;
                default: w_state_nxt = STOPPED;
            endcase
        end
        // Clear wins over increment; stopped holds phase.
        if (w_clr_press) begin
            w_presc_nxt = '0;
        end else if (r_state == RUNNING) begin
            w_presc_nxt = (r_presc == PMAX) ? '0 : r_presc + PW'(1);
        end
    end

    assign running = (r_state == RUNNING);
    assign enable  = running && (r_presc == PMAX);
    assign clear   = w_clr_press;

endmodule

// File: tb/tb_run_ctrl_tick.sv
// Scoreboard bench for run_ctrl_tick with DIV=4, DB_CYCLES=8, 20 ns clock.
// Stimulus pushes expected enable/clear cycles; a monitor pops and compares.
module tb_run_ctrl_tick;

    logic clk;
    logic rst_n;
    logic btn;
    logic clr;
    logic en;
    logic run;
    logic clr_o;

    int cyc;
    int n_total;
    int n_pass;
    int exp_en[$];
    int exp_clr[$];

    int kf, R, R2, R3, R4, c, P, k6;

    run_ctrl_tick #(.DIV(4), .DB_CYCLES(8)) dut (
        .clock   (clk),
        .reset   (rst_n),
        .btn_raw (btn),
        .clr_raw (clr),
        .enable  (en),
        .running (run),
        .clear   (clr_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        n_total = 0;
        n_pass  = 0;
    end

    always @(negedge clk) begin
        int e;
        if (en) begin
            n_total++;
            if (exp_en.size() == 0) begin
                $display("FAIL enable_unexpected got enable=1 at cyc=%0d want none", cyc);
            end else begin
                e = exp_en.pop_front();
                if (cyc == e) n_pass++;
                else $display("FAIL enable_cycle got cyc=%0d want cyc=%0d", cyc, e);
            end
        end
        if (clr_o) begin
            n_total++;
            if (exp_clr.size() == 0) begin
                $display("FAIL clear_unexpected got clear=1 at cyc=%0d want none", cyc);
            end else begin
                e = exp_clr.pop_front();
                if (cyc == e) n_pass++;
                else $display("FAIL clear_cycle got cyc=%0d want cyc=%0d", cyc, e);
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%b want=%b at cyc=%0d", name, act, exp, cyc);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", name, act, exp);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        btn   = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_enable", en, 1'b0);
        chk("rst_running", run, 1'b0);
        chk("rst_clear", clr_o, 1'b0);

        // Reset held 3 cycles while buttons toggle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            btn = ~btn;
            clr = ~clr;
            chk("rst_hold_running", run, 1'b0);
            chk("rst_hold_enable", en, 1'b0);
        end
        btn = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("idle_running", run, 1'b0);

        // Bounce then stable press.
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        repeat (2) @(negedge clk);
        btn = 1'b1;
        kf = cyc;
        R  = kf + 11;
        for (int i = 0; i < 16; i++) exp_en.push_back(R + 3 + 4 * i);
        wait_until(kf + 10);
        chk("bounce_running_pre", run, 1'b0);
        wait_until(kf + 11);
        chk("bounce_running_rise", run, 1'b1);
        wait_until(kf + 20);
        btn = 1'b0;
        wait_until(kf + 40);
        chk("bounce_no_second", run, 1'b1);

        // Stop with presc = 2.
        wait_until(R + 55);
        btn = 1'b1;
        wait_until(R + 65);
        chk("stop_running_pre", run, 1'b1);
        wait_until(R + 66);
        chk("stop_running_fall", run, 1'b0);
        chk("stop_enable_low", en, 1'b0);
        wait_until(R + 67);
        btn = 1'b0;
        wait_until(R + 79);
        chk_int("run_enable_count", 16 - exp_en.size(), 16);

        // Resume: first enable one cycle after running rises.
        wait_until(R + 80);
        btn = 1'b1;
        R2 = R + 91;
        c  = R2 + 20;
        P  = R2 + 50;
        for (int i = 0; i < 5; i++) exp_en.push_back(R2 + 1 + 4 * i);
        for (int i = 0; i < 7; i++) exp_en.push_back(c + 4 + 4 * i);
        exp_clr.push_back(c);
        exp_clr.push_back(P);
        wait_until(R2 - 1);
        chk("resume_running_pre", run, 1'b0);
        wait_until(R2);
        chk("resume_running_rise", run, 1'b1);
        wait_until(R + 92);
        btn = 1'b0;

        // Clear while running.
        wait_until(R2 + 10);
        clr = 1'b1;
        wait_until(c + 1);
        chk("clear_running_kept", run, 1'b1);
        chk("clear_one_cycle", clr_o, 1'b0);
        wait_until(R2 + 22);
        clr = 1'b0;

        // Start/stop and clear together.
        wait_until(R2 + 40);
        btn = 1'b1;
        clr = 1'b1;
        wait_until(P);
        chk("both_running_pre", run, 1'b1);
        wait_until(P + 1);
        chk("both_running_fall", run, 1'b0);
        wait_until(R2 + 52);
        btn = 1'b0;
        clr = 1'b0;

        // Restart shows presc restarted from 0.
        wait_until(R2 + 70);
        btn = 1'b1;
        R3 = R2 + 81;
        exp_en.push_back(R3 + 3);
        exp_en.push_back(R3 + 7);
        wait_until(R2 + 82);
        btn = 1'b0;
        wait_until(R3);
        chk("restart_running", run, 1'b1);

        // Asynchronous reset while enable is high.
        wait_until(R3 + 7);
        #5 rst_n = 1'b0;
        #1;
        chk("midrst_enable", en, 1'b0);
        chk("midrst_running", run, 1'b0);
        chk("midrst_clear", clr_o, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("postrst_running", run, 1'b0);
        repeat (2) @(negedge clk);
        k6  = cyc;
        btn = 1'b1;
        R4  = k6 + 11;
        exp_en.push_back(R4 + 3);
        wait_until(R4 - 1);
        chk("postrst_running_pre", run, 1'b0);
        wait_until(R4);
        chk("postrst_running_rise", run, 1'b1);
        wait_until(k6 + 12);
        btn = 1'b0;
        wait_until(R4 + 4);
        #5 rst_n = 1'b0;
        #1;

        chk_int("enable_queue_drained", exp_en.size(), 0);
        chk_int("clear_queue_drained", exp_clr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
